// File: rtl/debug_step_controller.sv
// rtl/debug_step_controller.sv - host command engine driving debug_enable/single_step of the clock-gating debugger
module debug_step_controller #(
    parameter int PULSE_HI     = 2,
    parameter int PULSE_LO     = 4,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic        phy_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    input  logic [7:0]  bp_value,
    input  logic [7:0]  clock_counter,
    output logic        debug_enable,
    output logic        single_step,
    output logic        busy,
    output logic [15:0] steps_done,
    output logic        bp_hit,
    output logic [15:0] status
);

    if (PULSE_HI < 2 || PULSE_LO < 4) begin : g_bad_param
        $error("debug_step_controller: illegal PULSE_HI/PULSE_LO (need PULSE_HI >= 2, PULSE_LO >= 4)");
    end

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP_HI, S_STEP_LO} state_t;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_HALT   = 2'b01;
    localparam logic [1:0] OP_STEP_N = 2'b10;
    localparam logic [1:0] OP_RUN_BP = 2'b11;

    localparam int PMAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [PW-1:0] HI_LAST = PW'(PULSE_HI - 1);
    localparam logic [PW-1:0] LO_LAST = PW'(PULSE_LO - 1);
    localparam state_t RESET_STATE = RESET_HALTED ? S_HALTED : S_RUN;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [15:0]   steps_q, steps_d;
    logic          bp_mode_q, bp_mode_d;
    logic          unlimited_q, unlimited_d;
    logic          abort_q, abort_d;
    logic          bp_hit_q, bp_hit_d;
    logic          err_q, err_d;
    logic          debug_enable_q, debug_enable_d;
    logic          single_step_q, single_step_d;
    logic          busy_q, busy_d;
    logic          halt_cmd;
    logic          last_step;

    assign halt_cmd  = cmd_valid && (cmd_op == OP_HALT);
    assign last_step = !unlimited_q && (remaining_q == 16'd1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        steps_d     = steps_q;
        bp_mode_d   = bp_mode_q;
        unlimited_d = unlimited_q;
        abort_d     = abort_q;
        bp_hit_d    = bp_hit_q;
        err_d       = err_q;
        case (state_q)
            S_RUN, S_HALTED: begin
                if (cmd_valid) begin
                    err_d = 1'b0;
                    case (cmd_op)
                        OP_RUN:  state_d = S_RUN;
                        OP_HALT: state_d = S_HALTED;
                        OP_STEP_N: begin
                            steps_d = 16'd0;
                            if (cmd_count == 16'd0) begin
                                state_d = S_HALTED;
                            end else begin
                                state_d     = S_STEP_HI;
                                phase_d     = '0;
                                remaining_d = cmd_count;
                                bp_mode_d   = 1'b0;
                                unlimited_d = 1'b0;
                                abort_d     = 1'b0;
                            end
                        end
                        default: begin
                            steps_d     = 16'd0;
                            bp_hit_d    = 1'b0;
                            state_d     = S_STEP_HI;
                            phase_d     = '0;
                            remaining_d = cmd_count;
                            bp_mode_d   = 1'b1;
                            unlimited_d = (cmd_count == 16'd0);
                            abort_d     = 1'b0;
                        end
                    endcase
                end
            end
            S_STEP_HI: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_HALT) abort_d = 1'b1;
                    else                   err_d   = 1'b1;
                end
                // A HALT cuts the high phase short but the step still counts.
                if (halt_cmd || phase_q == HI_LAST) begin
                    state_d = S_STEP_LO;
                    phase_d = '0;
                    steps_d = steps_q + 16'd1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_HALT) abort_d = 1'b1;
                    else                   err_d   = 1'b1;
                end
                if (phase_q == LO_LAST) begin
                    phase_d = '0;
                    if (!unlimited_q) remaining_d = remaining_q - 16'd1;
                    if (bp_mode_q && clock_counter == bp_value) begin
                        bp_hit_d = 1'b1;
                        state_d  = S_HALTED;
                    end else if (abort_q || halt_cmd || last_step) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_STEP_HI;
                    end
                    if (state_d == S_HALTED) abort_d = 1'b0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
        endcase
        debug_enable_d = (state_d != S_RUN);
        single_step_d  = (state_d == S_STEP_HI);
        busy_d         = (state_d == S_STEP_HI) || (state_d == S_STEP_LO);
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q        <= RESET_STATE;
            phase_q        <= '0;
            remaining_q    <= 16'd0;
            steps_q        <= 16'd0;
            bp_mode_q      <= 1'b0;
            unlimited_q    <= 1'b0;
            abort_q        <= 1'b0;
            bp_hit_q       <= 1'b0;
            err_q          <= 1'b0;
            debug_enable_q <= RESET_HALTED;
            single_step_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            remaining_q    <= remaining_d;
            steps_q        <= steps_d;
            bp_mode_q      <= bp_mode_d;
            unlimited_q    <= unlimited_d;
            abort_q        <= abort_d;
            bp_hit_q       <= bp_hit_d;
            err_q          <= err_d;
            debug_enable_q <= debug_enable_d;
            single_step_q  <= single_step_d;
            busy_q         <= busy_d;
        end
    end

    assign debug_enable = debug_enable_q;
    assign single_step  = single_step_q;
    assign busy         = busy_q;
    assign steps_done   = steps_q;
    assign bp_hit       = bp_hit_q;
    assign status       = {12'h000, bp_hit_q, err_q, busy_q, debug_enable_q};

endmodule
